// File: rtl/register_file_32x32_if.sv
// rtl/register_file_32x32_if.sv - read/write bus bundle for the 32x32 register file
//
// Purpose: groups the strobes, addresses and data of the register file.
// Signals:
//   read     1  read strobe; both read outputs load at the edge it is sampled high
//   write    1  write strobe; data_w is stored at addr_w
//   addr_r1  5  read port 1 register index
//   addr_r2  5  read port 2 register index
//   addr_w   5  write port register index
//   data_w   32 write data
//   data_r1  32 registered read data, port 1
//   data_r2  32 registered read data, port 2
// Modports: master drives strobes/addresses/write data, slave drives read data.

interface register_file_32x32_if;
    logic        read;
    logic        write;
    logic [4:0]  addr_r1;
    logic [4:0]  addr_r2;
    logic [4:0]  addr_w;
    logic [31:0] data_w;
    logic [31:0] data_r1;
    logic [31:0] data_r2;

    modport master (
        output read, write, addr_r1, addr_r2, addr_w, data_w,
        input  data_r1, data_r2
    );

    modport slave (
        input  read, write, addr_r1, addr_r2, addr_w, data_w,
        output data_r1, data_r2
    );
endinterface

// File: rtl/register_file_32x32.sv
// rtl/register_file_32x32.sv - 32 x 32-bit register file, 2 registered read ports, 1 write port
//
// Purpose: general-purpose register storage with a hardwired zero register.
// Ports:
//   clk    in   system clock, all state updates on the rising edge
//   rst_n  in   asynchronous active-low reset; clears registers and read outputs
//   bus    slave modport of register_file_32x32_if (strobes, addresses, data)
// Reads are read-before-write: a read and write to the same index at one edge
// returns the old content; the new value is visible at the next read edge.

module register_file_32x32 (
    input  logic                       clk,
    input  logic                       rst_n,
    register_file_32x32_if.slave       bus
);

    // Index 0 has no storage; the read mux supplies zero for it.
    logic [31:0] regs   [1:31];
    logic [31:0] mux_in [0:31];
    logic [31:0] wr_en;
    logic [31:0] rd_word1;
    logic [31:0] rd_word2;

    // 5-to-32 decode gated by the write strobe; bit 0 is never enabled so
    // writes to the zero register are dropped.
    always_comb begin
        wr_en = '0;
        for (int i = 1; i < 32; i++) begin
            wr_en[i] = bus.write && (bus.addr_w == 5'(i));
        end
    end

    always_comb begin
        mux_in[0] = '0;
        for (int i = 1; i < 32; i++) begin
            mux_in[i] = regs[i];
        end
    end

    assign rd_word1 = mux_in[bus.addr_r1];
    assign rd_word2 = mux_in[bus.addr_r2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 1; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int i = 1; i < 32; i++) begin
                if (wr_en[i]) begin
                    regs[i] <= bus.data_w;
                end
            end
        end
    end

    // Output flops sample the pre-edge register contents, which gives the
    // read-before-write behaviour on a same-index collision without a bypass.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.data_r1 <= '0;
            bus.data_r2 <= '0;
        end else if (bus.read) begin
            bus.data_r1 <= rd_word1;
            bus.data_r2 <= rd_word2;
        end
    end

endmodule

// File: tb/tb_register_file_32x32.sv
// tb/tb_register_file_32x32.sv - self-checking bench for register_file_32x32

module tb_register_file_32x32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    register_file_32x32_if bus ();

    register_file_32x32 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // Reference model: plain array of register values, index 0 always zero.
    logic [31:0] mem [0:31];
    logic [31:0] exp1;
    logic [31:0] exp2;
    int          n_checks = 0;
    int          n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, act, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 32; i++) mem[i] = 32'h0;
        exp1 = 32'h0;
        exp2 = 32'h0;
    endtask

    // One clock cycle: drive inputs, take the edge, advance the model,
    // then compare both read outputs shortly after the edge.
    task automatic step(input string tag, input logic rd, input logic wr,
                        input logic [4:0] a1, input logic [4:0] a2,
                        input logic [4:0] aw, input logic [31:0] dw);
        bus.read    = rd;
        bus.write   = wr;
        bus.addr_r1 = a1;
        bus.addr_r2 = a2;
        bus.addr_w  = aw;
        bus.data_w  = dw;
        @(posedge clk);
        if (rd) begin
            exp1 = mem[a1];
            exp2 = mem[a2];
        end
        if (wr && aw != 5'd0) mem[aw] = dw;
        #1;
        check_eq({tag, ".r1"}, bus.data_r1, exp1);
        check_eq({tag, ".r2"}, bus.data_r2, exp2);
    endtask

    initial begin
        bus.read    = 1'b0;
        bus.write   = 1'b0;
        bus.addr_r1 = '0;
        bus.addr_r2 = '0;
        bus.addr_w  = '0;
        bus.data_w  = '0;
        model_clear();

        repeat (2) @(posedge clk);
        #1;
        check_eq("reset.r1", bus.data_r1, 32'h0);
        check_eq("reset.r2", bus.data_r2, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Asynchronous reset mid-cycle.
        step("rst_wr", 1'b0, 1'b1, 5'd0, 5'd0, 5'd5, 32'hDEADBEEF);
        step("rst_rd", 1'b1, 1'b0, 5'd5, 5'd5, 5'd0, 32'h0);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("async_rst.r1", bus.data_r1, 32'h0);
        check_eq("async_rst.r2", bus.data_r2, 32'h0);
        model_clear();
        bus.read    = 1'b1;
        bus.write   = 1'b1;
        bus.addr_w  = 5'd6;
        bus.data_w  = 32'h55AA55AA;
        @(posedge clk);
        #1;
        check_eq("in_rst.r1", bus.data_r1, 32'h0);
        check_eq("in_rst.r2", bus.data_r2, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        step("post_rst", 1'b1, 1'b0, 5'd5, 5'd6, 5'd0, 32'h0);

        // Fill and readback pairs (i, 31-i).
        for (int i = 1; i < 32; i++)
            step("fill", 1'b0, 1'b1, 5'd0, 5'd0, 5'(i), 32'h1000_0000 + 32'(i));
        for (int i = 0; i < 32; i++)
            step("pair", 1'b1, 1'b0, 5'(i), 5'(31 - i), 5'd0, 32'h0);

        // Zero register ignores writes.
        step("r0_wr", 1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 32'hFFFFFFFF);
        step("r0_rd", 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0);

        // Collision: read-before-write.
        step("col_init", 1'b0, 1'b1, 5'd0, 5'd0, 5'd7, 32'hAAAA5555);
        step("col",      1'b1, 1'b1, 5'd7, 5'd7, 5'd7, 32'h12345678);
        check_eq("col.old", bus.data_r1, 32'hAAAA5555);
        step("col_next", 1'b1, 1'b0, 5'd7, 5'd7, 5'd0, 32'h0);
        check_eq("col.new", bus.data_r2, 32'h12345678);

        // Hold on READ=0.
        step("hold_w3", 1'b0, 1'b1, 5'd0, 5'd0, 5'd3, 32'h3);
        step("hold_w4", 1'b0, 1'b1, 5'd0, 5'd0, 5'd4, 32'h4);
        step("hold_r3", 1'b1, 1'b0, 5'd3, 5'd3, 5'd0, 32'h0);
        for (int i = 0; i < 5; i++) begin
            step("hold", 1'b0, 1'b0, 5'd4, 5'd4, 5'd0, 32'h0);
            check_eq("hold.fix", bus.data_r1, 32'h3);
        end
        step("hold_r4", 1'b1, 1'b0, 5'd4, 5'd3, 5'd0, 32'h0);
        check_eq("hold.r4", bus.data_r1, 32'h4);

        // Write gating.
        for (int i = 0; i < 3; i++)
            step("gate", 1'b0, 1'b0, 5'd1, 5'd2, 5'd9, 32'hCAFEF00D);
        step("gate_rd", 1'b1, 1'b0, 5'd9, 5'd9, 5'd0, 32'h0);
        check_eq("gate.r9", bus.data_r1, 32'h10000009);

        // Randomized traffic.
        for (int i = 0; i < 400; i++)
            step("rand", 1'($urandom), 1'($urandom), 5'($urandom), 5'($urandom),
                 5'($urandom), $urandom);

        // Final sweep of all registers.
        for (int i = 0; i < 32; i++)
            step("sweep", 1'b1, 1'b0, 5'(i), 5'(i ^ 5'h1f), 5'd0, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
